// File: rtl/mac_sequencer.sv
// Streams operand pairs into a DSP48A1 slice and captures the accumulated P every
// ACC_LEN taps. Define MACSEQ_OVF_EN to track 48-bit accumulator overflow via CARRYOUT.
module mac_sequencer #(
    parameter int ACC_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic        m_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ACC_LEN - 1);
    localparam logic [7:0]       OPM_FIRST = 8'h01;
    localparam logic [7:0]       OPM_ACC   = 8'h09;
    localparam logic [7:0]       OPM_HOLD  = 8'h08;

    logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [3:0]       last_pipe_q, last_pipe_d;
    logic [3:0]       tag_v_q, tag_v_d;
    logic [3:0]       tag_f_q, tag_f_d;
    logic [17:0]      dsp_a_q, dsp_a_d;
    logic [17:0]      dsp_b_q, dsp_b_d;
    logic [7:0]       dsp_opmode_q, dsp_opmode_d;
    logic             m_valid_q, m_valid_d;
    logic [47:0]      m_data_q, m_data_d;
    logic             m_ovf_q, m_ovf_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             handshake, is_first, is_last;

`ifndef MACSEQ_OVF_EN
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = ^{dsp_carryout, tag_v_q[3], tag_f_q[3]};
`endif

    always_comb begin
        is_first  = (tap_cnt_q == '0);
        is_last   = (tap_cnt_q == LAST_CNT);
        s_ready   = !(is_last && ((|last_pipe_q) || m_valid_q));
        handshake = s_valid && s_ready;

        tap_cnt_d = tap_cnt_q;
        dsp_a_d   = dsp_a_q;
        dsp_b_d   = dsp_b_q;
        if (handshake) begin
            tap_cnt_d = is_last ? '0 : tap_cnt_q + 1'b1;
            dsp_a_d   = s_a;
            dsp_b_d   = s_b;
        end

        // Tag stage 0 is the tap the slice registers OPMODE for on the next edge.
        tag_v_d     = {tag_v_q[2:0], handshake};
        tag_f_d     = {tag_f_q[2:0], handshake && is_first};
        last_pipe_d = {last_pipe_q[2:0], handshake && is_last};

        if (!tag_v_q[0])
            dsp_opmode_d = OPM_HOLD;
        else if (tag_f_q[0])
            dsp_opmode_d = OPM_FIRST;
        else
            dsp_opmode_d = OPM_ACC;

`ifdef MACSEQ_OVF_EN
        ovf_acc_d = ovf_acc_q;
        if (tag_v_q[3])
            ovf_acc_d = tag_f_q[3] ? dsp_carryout : (ovf_acc_q || dsp_carryout);
`else
        ovf_acc_d = 1'b0;
`endif

        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ovf_d   = m_ovf_q;
        if (m_valid_q && m_ready)
            m_valid_d = 1'b0;
        // The last tap's own carry lands on the capture edge, so report the updated flag.
        if (last_pipe_q[3]) begin
            m_valid_d = 1'b1;
            m_data_d  = dsp_p;
            m_ovf_d   = ovf_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_q    <= '0;
            last_pipe_q  <= '0;
            tag_v_q      <= '0;
            tag_f_q      <= '0;
            dsp_a_q      <= '0;
            dsp_b_q      <= '0;
            dsp_opmode_q <= OPM_HOLD;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_ovf_q      <= 1'b0;
            ovf_acc_q    <= 1'b0;
        end else begin
            tap_cnt_q    <= tap_cnt_d;
            last_pipe_q  <= last_pipe_d;
            tag_v_q      <= tag_v_d;
            tag_f_q      <= tag_f_d;
            dsp_a_q      <= dsp_a_d;
            dsp_b_q      <= dsp_b_d;
            dsp_opmode_q <= dsp_opmode_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_ovf_q      <= m_ovf_d;
            ovf_acc_q    <= ovf_acc_d;
        end
    end

    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_opmode = dsp_opmode_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_ovf      = m_ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: four instances (ACC_LEN 4, 2, 1, 4100), each wired to a
// behavioural DSP48A1 model (A1/B1, OPMODE, M, P and CARRYOUT registers).
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic [3:0]        s_valid, s_ready, m_valid, m_ready, m_ovf;
    logic [3:0][17:0]  s_a, s_b, dsp_a, dsp_b;
    logic [3:0][7:0]   dsp_opmode;
    logic [3:0][47:0]  m_data;

    int checks = 0;
    int errors = 0;

`ifdef MACSEQ_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif
    // 4096 full-scale unsigned products sum to just under 2^48; 4100 of them wrap.
    localparam logic [63:0] FULL_SUM = 64'd4100 * 64'd68718952449;
    localparam logic [47:0] EXP_WRAP = FULL_SUM[47:0];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [17:0] a1_q, b1_q;
        logic [7:0]  opm_q;
        logic [35:0] m_q;
        logic [47:0] p_q;
        logic        co_q;
        logic [48:0] sum;

        always_comb
            sum = ((opm_q[3:2] == 2'b10) ? {1'b0, p_q} : 49'd0)
                + ((opm_q[1:0] == 2'b01) ? {13'd0, m_q} : 49'd0);

        always @(posedge clk) begin
            if (rst) begin
                a1_q <= '0; b1_q <= '0; opm_q <= '0; m_q <= '0; p_q <= '0; co_q <= 1'b0;
            end else begin
                a1_q  <= dsp_a[g];
                b1_q  <= dsp_b[g];
                opm_q <= dsp_opmode[g];
                m_q   <= a1_q * b1_q;
                p_q   <= sum[47:0];
                co_q  <= sum[48];
            end
        end

        mac_sequencer #(
            .ACC_LEN((g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 4100),
            .CNT_W  (16)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .s_valid     (s_valid[g]),
            .s_ready     (s_ready[g]),
            .s_a         (s_a[g]),
            .s_b         (s_b[g]),
            .dsp_a       (dsp_a[g]),
            .dsp_b       (dsp_b[g]),
            .dsp_opmode  (dsp_opmode[g]),
            .dsp_p       (p_q),
            .dsp_carryout(co_q),
            .m_valid     (m_valid[g]),
            .m_ready     (m_ready[g]),
            .m_data      (m_data[g]),
            .m_ovf       (m_ovf[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = '0; m_ready = '0; s_a = '0; s_b = '0;
        repeat (3) tick();
        checks++; if (s_ready !== 4'hF) begin errors++; $display("FAIL rst_s_ready got %h want f", s_ready); end
        checks++; if (m_valid !== 4'h0) begin errors++; $display("FAIL rst_m_valid got %h want 0", m_valid); end
        checks++; if (m_ovf !== 4'h0) begin errors++; $display("FAIL rst_m_ovf got %h want 0", m_ovf); end
        checks++; if (m_data[0] !== 48'd0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data[0]); end
        checks++; if (dsp_a[0] !== 18'd0 || dsp_b[0] !== 18'd0) begin errors++; $display("FAIL rst_dsp_ab got %h/%h want 0/0", dsp_a[0], dsp_b[0]); end
        checks++; if (dsp_opmode !== {4{8'h08}}) begin errors++; $display("FAIL rst_opmode got %h want 08080808", dsp_opmode); end
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 4'hF) begin errors++; $display("FAIL post_rst_s_ready got %h want f", s_ready); end
    endtask

    task automatic test_back_to_back();
        int idx = 0, last_c = -1, got = -1;
        logic [47:0] data = '0;
        logic [7:0] opm [12];
        logic hs;
        m_ready[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_valid[0] = (idx < 4);
            s_a[0] = 18'(2 * idx + 1);
            s_b[0] = 18'(2 * idx + 2);
            hs = s_valid[0] & s_ready[0];
            tick();
            if (hs) begin idx++; if (idx == 4) last_c = c; end
            opm[c] = dsp_opmode[0];
            if (m_valid[0] && got < 0) begin got = c; data = m_data[0]; end
        end
        s_valid[0] = 1'b0;
        checks++; if (idx != 4) begin errors++; $display("FAIL b2b_taps got %0d want 4", idx); end
        checks++; if ({opm[1], opm[2], opm[3], opm[4], opm[5]} !== 40'h01_09_09_09_08) begin
            errors++; $display("FAIL b2b_opmode got %h %h %h %h %h want 01 09 09 09 08", opm[1], opm[2], opm[3], opm[4], opm[5]);
        end
        checks++; if (got - last_c != 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", got - last_c); end
        checks++; if (data !== 48'h64) begin errors++; $display("FAIL b2b_data got %h want 64", data); end
    endtask

    task automatic test_bubbles();
        int idx = 0, last_c = -1, got = -1;
        logic [47:0] data = '0;
        logic [7:0] opm [14];
        logic hs;
        m_ready[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            s_valid[0] = (c % 2 == 0) && (idx < 4);
            s_a[0] = 18'(2 * idx + 1);
            s_b[0] = 18'(2 * idx + 2);
            hs = s_valid[0] & s_ready[0];
            tick();
            if (hs) begin idx++; if (idx == 4) last_c = c; end
            opm[c] = dsp_opmode[0];
            if (m_valid[0] && got < 0) begin got = c; data = m_data[0]; end
        end
        s_valid[0] = 1'b0;
        checks++; if ({opm[1], opm[2], opm[3], opm[4], opm[5], opm[6], opm[7], opm[8]} !== 64'h01_08_09_08_09_08_09_08) begin
            errors++; $display("FAIL bubble_opmode got %h %h %h %h %h %h %h %h want 01 08 09 08 09 08 09 08",
                               opm[1], opm[2], opm[3], opm[4], opm[5], opm[6], opm[7], opm[8]);
        end
        checks++; if (got - last_c != 4) begin errors++; $display("FAIL bubble_latency got %0d want 4", got - last_c); end
        checks++; if (data !== 48'h64) begin errors++; $display("FAIL bubble_data got %h want 64", data); end
    endtask

    task automatic test_hold_stall();
        int idx = 0, last_c = -1, got = -1;
        logic [47:0] data = '0;
        logic hs;
        logic [17:0] v;
        m_ready[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            v = (idx < 2) ? 18'd1 : (idx == 2) ? 18'd2 : 18'd3;
            s_valid[1] = (idx < 4); s_a[1] = v; s_b[1] = v;
            hs = s_valid[1] & s_ready[1];
            tick();
            if (hs) begin idx++; if (idx == 2) last_c = c; end
            if (m_valid[1] && got < 0) begin got = c; data = m_data[1]; end
        end
        checks++; if (idx != 3) begin errors++; $display("FAIL hold_taps_taken got %0d want 3", idx); end
        checks++; if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL hold_s_ready got %b want 0", s_ready[1]); end
        checks++; if (got - last_c != 4) begin errors++; $display("FAIL hold_first_latency got %0d want 4", got - last_c); end
        checks++; if (m_valid[1] !== 1'b1 || m_data[1] !== 48'd2) begin
            errors++; $display("FAIL hold_first_result got %b/%0d want 1/2", m_valid[1], m_data[1]);
        end
        m_ready[1] = 1'b1;
        tick();
        m_ready[1] = 1'b0;
        checks++; if (m_valid[1] !== 1'b0) begin errors++; $display("FAIL hold_pop got %b want 0", m_valid[1]); end
        got = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            s_valid[1] = (idx < 4); s_a[1] = 18'd3; s_b[1] = 18'd3;
            hs = s_valid[1] & s_ready[1];
            tick();
            if (hs) begin idx++; if (idx == 4) last_c = c; end
            if (m_valid[1] && got < 0) begin got = c; data = m_data[1]; end
        end
        s_valid[1] = 1'b0;
        checks++; if (last_c != 0 || got - last_c != 4) begin
            errors++; $display("FAIL hold_second_timing got hs %0d valid %0d want hs 0 valid 4", last_c, got);
        end
        checks++; if (data !== 48'd13) begin errors++; $display("FAIL hold_second_data got %0d want 13", data); end
        m_ready[1] = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        int idx = 0, last_c = -1, got = -1, nvalid = 0;
        logic [47:0] data = '0;
        logic hs;
        m_ready[0] = 1'b1;
        s_valid[0] = 1'b1; s_a[0] = 18'd5; s_b[0] = 18'd5;
        repeat (2) tick();
        s_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dsp_a[0] !== 18'd0 || dsp_opmode[0] !== 8'h08 || s_ready[0] !== 1'b1) begin
            errors++; $display("FAIL mid_rst_state got a=%h opm=%h rdy=%b want 0/08/1", dsp_a[0], dsp_opmode[0], s_ready[0]);
        end
        for (int c = 0; c < 14; c++) begin
            s_valid[0] = (idx < 4); s_a[0] = 18'd2; s_b[0] = 18'd2;
            hs = s_valid[0] & s_ready[0];
            tick();
            if (hs) begin idx++; if (idx == 4) last_c = c; end
            if (m_valid[0]) begin
                nvalid++;
                if (got < 0) begin got = c; data = m_data[0]; end
            end
        end
        s_valid[0] = 1'b0;
        checks++; if (nvalid != 1) begin errors++; $display("FAIL mid_rst_results got %0d want 1", nvalid); end
        checks++; if (got - last_c != 4) begin errors++; $display("FAIL mid_rst_latency got %0d want 4", got - last_c); end
        checks++; if (data !== 48'd16) begin errors++; $display("FAIL mid_rst_data got %0d want 16", data); end
    endtask

    task automatic test_acc_len1();
        logic [47:0] q [$];
        logic [47:0] want;
        int nhs = 0, nready = 0, nres = 0;
        logic hs;
        m_ready[2] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            s_valid[2] = (c < 20); s_a[2] = 18'(c + 1); s_b[2] = 18'd3;
            if (c < 20 && s_ready[2]) nready++;
            hs = s_valid[2] & s_ready[2];
            tick();
            if (hs) begin nhs++; q.push_back(48'((c + 1) * 3)); end
            if (m_valid[2]) begin
                nres++;
                want = (q.size() > 0) ? q.pop_front() : 48'hFFFF_FFFF_FFFF;
                checks++; if (m_data[2] !== want) begin errors++; $display("FAIL len1_data got %0d want %0d", m_data[2], want); end
            end
        end
        s_valid[2] = 1'b0;
        checks++; if (nhs != 4 || nready != 4) begin errors++; $display("FAIL len1_duty got hs %0d ready %0d want 4/4", nhs, nready); end
        checks++; if (nres != 4) begin errors++; $display("FAIL len1_results got %0d want 4", nres); end
    endtask

    task automatic stream_group(input int n, input logic [17:0] a, input logic [17:0] b,
                                output logic [47:0] d, output logic o, output int lat);
        int idx = 0, c = 0, last = 0;
        logic hs;
        lat = -1; d = '0; o = 1'b0;
        m_ready[3] = 1'b1;
        while ((idx < n || lat < 0) && c < n + 40) begin
            s_valid[3] = (idx < n); s_a[3] = a; s_b[3] = b;
            hs = s_valid[3] & s_ready[3];
            tick();
            c++;
            if (hs) begin idx++; if (idx == n) last = c; end
            if (m_valid[3] && lat < 0 && idx == n) begin lat = c - last; d = m_data[3]; o = m_ovf[3]; end
        end
        s_valid[3] = 1'b0;
    endtask

    task automatic test_overflow();
        logic [47:0] d;
        logic o;
        int lat;
        stream_group(4100, 18'h3FFFF, 18'h3FFFF, d, o, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL ovf_latency got %0d want 4", lat); end
        checks++; if (d !== EXP_WRAP) begin errors++; $display("FAIL ovf_data got %h want %h", d, EXP_WRAP); end
        checks++; if (o !== OVF_EXP) begin errors++; $display("FAIL ovf_flag got %b want %b", o, OVF_EXP); end
        stream_group(4100, 18'd1, 18'd1, d, o, lat);
        checks++; if (d !== 48'd4100) begin errors++; $display("FAIL ovf_next_data got %0d want 4100", d); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %b want 0", o); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_hold_stall();
        test_mid_reset();
        test_acc_len1();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
